// File: rtl/ps_sched_pkg.sv
// Shared constants for the parallel-to-serial word scheduler: word geometry,
// the default idle filler and the FSM state encodings.
package ps_sched_pkg;

    localparam int WORD_W        = 10;
    localparam int BITS_PER_WORD = 10;
    localparam int CNT_W         = 4;

    localparam logic [WORD_W-1:0] IDLE_WORD_DEF = 10'h17c;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        RUN  = 2'd1
    } sched_state_e;

    // Serial bit position: 0..BITS_PER_WORD-1, then wrap.
    function automatic logic [CNT_W-1:0] bit_cnt_next(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_W'(BITS_PER_WORD - 1)) ? '0 : cnt + CNT_W'(1);
    endfunction

endpackage

// File: rtl/ps_word_scheduler_if.sv
// Bus between two word requesters and the scheduler, plus the parallel word
// and status driven towards the serialiser.
interface ps_word_scheduler_if;
    import ps_sched_pkg::*;

    // Handshake: a requester raises reqN with datN and holds both stable; the
    // word transfers on the rising edge where reqN && ackN. ackN is a one-cycle
    // pulse that can only appear in a load cycle (wordStrobe high).
    logic              req0;
    logic [WORD_W-1:0] dat0;
    logic              ack0;
    logic              req1;
    logic [WORD_W-1:0] dat1;
    logic              ack1;

    logic [WORD_W-1:0] entradas;
    logic              wordStrobe;
    logic              grant;
    logic              idle;
    logic [1:0]        state;

    modport master (
        output req0, dat0, req1, dat1,
        input  ack0, ack1, entradas, wordStrobe, grant, idle, state
    );

    modport slave (
        input  req0, dat0, req1, dat1,
        output ack0, ack1, entradas, wordStrobe, grant, idle, state
    );

endinterface

// File: rtl/ps_rr_arbiter.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that was not served last.
module ps_rr_arbiter (
    input  logic req0,
    input  logic req1,
    input  logic lastGrant,
    output logic gnt,
    output logic valid
);

    always_comb begin
        gnt   = 1'b0;
        valid = req0 | req1;
        if (req0 && req1) begin
            gnt = ~lastGrant;
        end else if (req1) begin
            gnt = 1'b1;
        end
    end

endmodule

// File: rtl/ps_word_scheduler.sv
// Word scheduler feeding a 10-bit serialiser from two requesters.
// Optional macro PS_SCHED_SYNC_EN adds a post-reset SYNC phase of idle words.
module ps_word_scheduler
    import ps_sched_pkg::*;
#(
    parameter int                SYNC_WORDS = 4,
    parameter logic [WORD_W-1:0] IDLE_WORD  = IDLE_WORD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enb,
    ps_word_scheduler_if.slave bus
);

`ifdef PS_SCHED_SYNC_EN
    localparam sched_state_e RESET_STATE = SYNC;
`else
    localparam sched_state_e RESET_STATE = RUN;
`endif

    if (SYNC_WORDS < 1 || SYNC_WORDS > 15) begin : g_bad_sync_words
        $error("ps_word_scheduler: SYNC_WORDS must be in 1..15");
    end

    sched_state_e      r_state;
    sched_state_e      w_next_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WORD_W-1:0] r_entradas;
    logic              r_grant;
    logic              r_idle;
    logic              r_last_grant;

    logic              w_load;
    logic              w_arb_gnt;
    logic              w_arb_valid;
    logic              w_ack0;
    logic              w_ack1;
    logic              w_upd_word;
    logic [WORD_W-1:0] w_new_word;
    logic              w_new_idle;
    logic              w_new_grant;

`ifdef PS_SCHED_SYNC_EN
    logic [CNT_W-1:0]  r_sync_cnt;
`endif

    assign w_load = enb && (r_bit_cnt == CNT_W'(BITS_PER_WORD - 1));

    ps_rr_arbiter u_arb (
        .req0      (bus.req0),
        .req1      (bus.req1),
        .lastGrant (r_last_grant),
        .gnt       (w_arb_gnt),
        .valid     (w_arb_valid)
    );

    always_comb begin
        w_next_state = r_state;
        w_upd_word   = 1'b0;
        w_new_word   = IDLE_WORD;
        w_new_idle   = 1'b1;
        w_new_grant  = r_grant;
        w_ack0       = 1'b0;
        w_ack1       = 1'b0;
        case (r_state)
            RUN: begin
                if (w_load) begin
                    w_upd_word = 1'b1;
                    if (w_arb_valid) begin
                        w_new_word  = w_arb_gnt ? bus.dat1 : bus.dat0;
                        w_new_idle  = 1'b0;
                        w_new_grant = w_arb_gnt;
                        w_ack0      = ~w_arb_gnt;
                        w_ack1      = w_arb_gnt;
                    end
                end
            end
            default: begin
`ifdef PS_SCHED_SYNC_EN
                // SYNC, and any stray encoding, emits idle words and never acks.
                if (w_load) begin
                    w_upd_word = 1'b1;
                    if (r_sync_cnt == CNT_W'(SYNC_WORDS - 1)) begin
                        w_next_state = RUN;
                    end
                end
                if (r_state != SYNC) begin
                    w_next_state = SYNC;
                end
`else
                w_next_state = RUN;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= RESET_STATE;
            r_bit_cnt    <= '0;
            r_entradas   <= IDLE_WORD;
            r_idle       <= 1'b1;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (enb) begin
            r_state   <= w_next_state;
            r_bit_cnt <= bit_cnt_next(r_bit_cnt);
            if (w_upd_word) begin
                r_entradas <= w_new_word;
                r_idle     <= w_new_idle;
                r_grant    <= w_new_grant;
                if (!w_new_idle) begin
                    r_last_grant <= w_new_grant;
                end
            end
        end
    end

`ifdef PS_SCHED_SYNC_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_cnt <= '0;
        end else if (w_load && r_state == SYNC &&
                     r_sync_cnt != CNT_W'(SYNC_WORDS - 1)) begin
            r_sync_cnt <= r_sync_cnt + CNT_W'(1);
        end
    end
`endif

    assign bus.ack0       = w_ack0;
    assign bus.ack1       = w_ack1;
    assign bus.entradas   = r_entradas;
    assign bus.wordStrobe = w_load;
    assign bus.grant      = r_grant;
    assign bus.idle       = r_idle;
    assign bus.state      = (r_state == RUN) ? RUN : SYNC;

endmodule

// File: doc/ps_word_scheduler.md
PS_WORD_SCHEDULER -- requirements
Module: ps_word_scheduler

Interface
REQ-001 Parameter SYNC_WORDS, default 4, number of IDLE_WORD loads after reset before data is accepted; legal range 1..15.
REQ-002 Parameter IDLE_WORD, default 10'h17c, filler word sent when no requester is served.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 enb  in  1  enable; low freezes all state and forces ack0/ack1/wordStrobe low.
REQ-006 req0  in  1  requester 0 has a word pending; held with dat0 stable until ack0.
REQ-007 dat0  in  10  requester 0 word.
REQ-008 ack0  out  1  one-cycle accept pulse; transfer occurs on the edge where req0 && ack0.
REQ-009 req1 / dat1 / ack1: same as req0 / dat0 / ack0, for requester 1.
REQ-010 entradas  out  10  registered parallel word driven to the paraleloSerial input; stable for 10 clk cycles.
REQ-011 wordStrobe  out  1  high during the load cycle (bitCnt==9 && enb).
REQ-012 grant  out  1  requester index owning the current entradas word; meaningful only when idle=0.
REQ-013 idle  out  1  current entradas word is IDLE_WORD.
REQ-014 state  out  2  FSM state: SYNC=2'd0, RUN=2'd1.

Function
REQ-015 bitCnt (4 bit) shall count 0..9 when enb=1 and wrap from 9 to 0; the load cycle is bitCnt==9 && enb.
REQ-016 In SYNC, each load cycle shall load IDLE_WORD, set idle=1, and assert neither ack.
REQ-017 SYNC shall move to RUN on the edge of the SYNC_WORDS-th SYNC load, counted by syncCnt.
REQ-018 RUN load-cycle arbitration: only req0 -> grant 0; only req1 -> grant 1; both -> requester != lastGrant; neither -> IDLE_WORD.
REQ-019 On the load cycle, the served requester's ack shall assert combinationally.
REQ-020 On the edge ending the load cycle, entradas, grant, idle and lastGrant shall update; with no requester, lastGrant is unchanged.
REQ-021 Latency: a word accepted in a load cycle appears on entradas on the next edge and holds through the following 10 cycles.
REQ-022 Requests are sampled only in the load cycle; a req raised and dropped between load cycles is ignored with no ack.
REQ-023 enb low in a would-be load cycle: no load and no ack; the load occurs when enb returns with bitCnt still 9.
REQ-024 RUN shall have no exit other than reset; state 2'd2 and 2'd3 are unreachable and shall decode to SYNC.

Reset
REQ-025 Asynchronous reset (rst=0) values: entradas=IDLE_WORD, idle=1, grant=0, ack0=ack1=0, wordStrobe=0, bitCnt=0, syncCnt=0, lastGrant=1, state=SYNC.
REQ-026 Reset mid-word shall abort the word immediately with no ack; counting restarts at bitCnt=0 after release.

Configuration
REQ-027 With PS_SCHED_SYNC_EN defined: SYNC state and syncCnt are present and behave per REQ-016/017.
REQ-028 Without PS_SCHED_SYNC_EN: reset enters RUN directly, syncCnt is absent, SYNC_WORDS is ignored, and state reads 2'd1.

Structure
REQ-029 Package ps_sched_pkg shall hold WORD_W=10, BITS_PER_WORD=10, the default IDLE_WORD, and the state encodings SYNC/RUN.
REQ-030 Sub-module ps_rr_arbiter shall implement the 2-way round-robin of REQ-018 (inputs req0, req1, lastGrant; outputs gnt, valid); the counters and FSM stay in the top level.

Verification
REQ-031 Reset release with the macro on, req0=1 dat0=10'h36c: 4 IDLE words (10'h17c); first ack0 in the 5th load cycle; 10'h36c on entradas the next edge.
REQ-032 Both req held in RUN, dat0=10'h3e0, dat1=10'h01f: entradas alternates 10'h3e0 / 10'h01f every 10 cycles, starting with requester 0.
REQ-033 No requests in RUN: entradas=10'h17c, idle=1, no ack, wordStrobe pulses every 10th cycle.
REQ-034 enb low for 7 cycles spanning bitCnt=9: bitCnt, entradas and ack frozen; load happens in the first enb-high cycle.
REQ-035 rst pulled low at bitCnt=5 while 10'h1d5 is on entradas: entradas=10'h17c immediately, no ack, SYNC restarts.
REQ-036 Macro off, req1=1 dat1=10'h36d at reset release: ack1 in the first load cycle (cycle 10); state=2'd1 throughout.
